// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, opcodes, fetch-state and instruction-type
// encodings, and the IF/ID payload.
package mips_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 6;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;
    localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2,
        FS_HALT  = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        IT_R    = 2'd0,
        IT_J    = 2'd1,
        IT_HALT = 2'd2,
        IT_I    = 2'd3
    } instr_type_e;

    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

    // Coarse instruction class from the primary opcode; shared with decode.
    function automatic instr_type_e decode_type(input logic [OPW-1:0] op);
        instr_type_e t;
        case (op)
            OP_RTYPE: t = IT_R;
            OP_J:     t = IT_J;
            OP_HALT:  t = IT_HALT;
            default:  t = IT_I;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, redirect input and IF/ID output.
interface if_stage_if;
    import mips_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            id_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus4;
    logic            instr_valid;
    logic            halted;

    modport master (
        output imem_req, imem_addr, instruction, pc_out, pc_plus4, instr_valid, halted,
        input  imem_ack, imem_rdata, id_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instruction, pc_out, pc_plus4, instr_valid, halted,
        output imem_ack, imem_rdata, id_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/if_id_reg.sv
// One-entry IF/ID pipeline register: load captures a payload and marks it valid,
// clear (squash) or consume (delivered) drops the valid flag.
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   clear,
    input  logic   consume,
    input  if_id_t load_data,
    output if_id_t data,
    output logic   valid
);

    if_id_t data_d, data_q;
    logic   valid_d, valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (clear || consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, fetches over req/ack, hands words to
// decode through the IF/ID register, follows redirects and stops after HALT.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [OPW-1:0]  HALT_OPCODE = OP_HALT
) (
    input  logic          clk,
    input  logic          rst_n,
    if_stage_if.master    bus
);

    fetch_state_e    state_d, state_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic            pend_d, pend_q;
    logic [XLEN-1:0] tgt_d, tgt_q;
    logic            req_d, req_q;
    logic            halted_d, halted_q;

    logic            load, clear, consume;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] redir_aligned;
    if_id_t          load_data, id_data;
    logic            id_valid;
    logic            unused_redirect_lsbs;

    assign pc_inc               = pc_q + XLEN'(4);
    assign redir_aligned        = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
    assign load_data            = '{instruction: bus.imem_rdata, pc: pc_q, pc_plus4: pc_inc};

    // Next-state, PC and IF/ID control.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;
        load    = 1'b0;
        clear   = 1'b0;
        consume = 1'b0;

        case (state_q)
            FS_IDLE: state_d = FS_FETCH;

            FS_FETCH: begin
                if (bus.imem_ack) begin
                    // A same-cycle redirect beats the latched one; the fetched word is dropped.
                    if (bus.redirect_valid) begin
                        pc_d   = redir_aligned;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        pc_d   = tgt_q;
                        pend_d = 1'b0;
                    end else begin
                        load    = 1'b1;
                        pc_d    = pc_inc;
                        state_d = (bus.imem_rdata[XLEN-1:XLEN-OPW] == HALT_OPCODE) ? FS_HALT
                                                                                   : FS_HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    pend_d = 1'b1;
                    tgt_d  = redir_aligned;
                end
            end

            FS_HOLD: begin
                if (bus.redirect_valid) begin
                    clear   = 1'b1;
                    pc_d    = redir_aligned;
                    state_d = FS_FETCH;
                end else if (bus.id_ready) begin
                    consume = 1'b1;
                    state_d = FS_FETCH;
                end
            end

            FS_HALT: begin
                if (bus.id_ready && id_valid) begin
                    consume = 1'b1;
                end
            end

            default: state_d = FS_IDLE;
        endcase

        req_d    = (state_d == FS_FETCH);
        halted_d = (state_d == FS_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FS_IDLE;
            pc_q     <= RESET_PC;
            pend_q   <= 1'b0;
            tgt_q    <= '0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            tgt_q    <= tgt_d;
            req_q    <= req_d;
            halted_q <= halted_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .clear     (clear),
        .consume   (consume),
        .load_data (load_data),
        .data      (id_data),
        .valid     (id_valid)
    );

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instruction = id_data.instruction;
    assign bus.pc_out      = id_data.pc;
    assign bus.pc_plus4    = id_data.pc_plus4;
    assign bus.instr_valid = id_valid;
    assign bus.halted      = halted_q;

endmodule
